// File: rtl/sb_drain_pkg.sv
// Shared types for the store-buffer drain path: entry layout, drain FSM states
// and the byte-lane merge helper.
package sb_drain_pkg;

    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;
    localparam int SB_STRB_W = SB_DATA_W / 8;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic [SB_STRB_W-1:0] strb;
    } sb_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } sb_drain_state_e;

    typedef struct packed {
        logic [SB_DATA_W-1:0] data;
        logic [SB_STRB_W-1:0] strb;
    } sb_merge_t;

    // Newer bytes win; strobes accumulate.
    function automatic sb_merge_t sb_byte_merge(
        input logic [SB_DATA_W-1:0] old_data,
        input logic [SB_STRB_W-1:0] old_strb,
        input logic [SB_DATA_W-1:0] new_data,
        input logic [SB_STRB_W-1:0] new_strb
    );
        sb_merge_t r;
        r.data = old_data;
        r.strb = old_strb;
        for (int i = 0; i < SB_STRB_W; i++) begin
            if (new_strb[i]) begin
                r.data[8*i +: 8] = new_data[8*i +: 8];
                r.strb[i]        = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/handshake_if.sv
// Valid/ready handshake carrying one committed store-buffer entry per transfer.
interface handshake_if;
    import sb_drain_pkg::*;

    logic      valid;
    logic      ready;
    sb_entry_t data;

    modport sender   (output valid, output data, input  ready);
    modport receiver (input  valid, input  data, output ready);
endinterface

// File: rtl/sb_drain.sv
// Store-buffer drain: one committed store -> one single-beat write, one write outstanding.
// Latency: accept N -> request N+1; response M -> ready M+1. Backpressure: ready only in IDLE.
// Build option SB_DRAIN_MERGE_EN: same-word entries merge into a stalled request.
module sb_drain
    import sb_drain_pkg::*;
#(
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    handshake_if.receiver       sb_entry_receiver,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_data_o,
    output logic [DATA_W/8-1:0] mem_strb_o,
    input  logic                mem_resp_valid_i,
    input  logic                mem_resp_err_i,
    output logic                busy_o,
    output logic                err_o,
    output logic [31:0]         store_cnt_o
);

    localparam int STRB_W = DATA_W / 8;

    sb_drain_state_e     state;
    sb_entry_t           in_entry;
    logic [ADDR_W-1:0]   in_addr;
    logic [DATA_W-1:0]   in_data;
    logic [STRB_W-1:0]   in_strb;

    assign in_entry = sb_entry_receiver.data;
    assign in_addr  = ADDR_W'(in_entry.addr);
    assign in_data  = DATA_W'(in_entry.data);
    assign in_strb  = STRB_W'(in_entry.strb);

`ifdef SB_DRAIN_MERGE_EN
    logic      merge_hit;
    sb_merge_t merged;

    // Merging is only safe while the request is still stalled, never on the accept edge.
    assign merge_hit = (state == REQ) && !mem_req_ready_i &&
                       (in_addr[ADDR_W-1:2] == mem_addr_o[ADDR_W-1:2]);
    assign merged    = sb_byte_merge(SB_DATA_W'(mem_data_o), SB_STRB_W'(mem_strb_o),
                                     in_entry.data, in_entry.strb);
    assign sb_entry_receiver.ready = (state == IDLE) || merge_hit;
`else
    assign sb_entry_receiver.ready = (state == IDLE);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            mem_req_valid_o <= 1'b0;
            mem_addr_o      <= '0;
            mem_data_o      <= '0;
            mem_strb_o      <= '0;
            busy_o          <= 1'b0;
            err_o           <= 1'b0;
            store_cnt_o     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sb_entry_receiver.valid) begin
                        state           <= REQ;
                        mem_req_valid_o <= 1'b1;
                        busy_o          <= 1'b1;
                        mem_addr_o      <= {in_addr[ADDR_W-1:2], 2'b00};
                        mem_data_o      <= in_data;
                        mem_strb_o      <= in_strb;
                    end
                end
                REQ: begin
                    if (mem_req_ready_i) begin
                        state           <= WAIT;
                        mem_req_valid_o <= 1'b0;
                    end
`ifdef SB_DRAIN_MERGE_EN
                    else if (sb_entry_receiver.valid && merge_hit) begin
                        mem_data_o <= DATA_W'(merged.data);
                        mem_strb_o <= STRB_W'(merged.strb);
                    end
`endif
                end
                WAIT: begin
                    if (mem_resp_valid_i) begin
                        state       <= IDLE;
                        busy_o      <= 1'b0;
                        store_cnt_o <= store_cnt_o + 32'd1;
                        if (mem_resp_err_i) begin
                            err_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    state           <= IDLE;
                    mem_req_valid_o <= 1'b0;
                    busy_o          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sb_drain.sv
// Bench for sb_drain: directed scenarios plus randomized stores against a
// transaction-level model (expected write per entry, count, sticky error).
module tb_sb_drain;
    import sb_drain_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req_valid, mem_req_ready = 1'b0;
    logic [31:0] mem_addr, mem_data;
    logic [3:0]  mem_strb;
    logic        mem_resp_valid = 1'b0, mem_resp_err = 1'b0;
    logic        busy, err;
    logic [31:0] store_cnt;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;
    bit exp_err = 1'b0;

    handshake_if sb_if();

    sb_drain dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sb_entry_receiver(sb_if),
        .mem_req_valid_o  (mem_req_valid),
        .mem_req_ready_i  (mem_req_ready),
        .mem_addr_o       (mem_addr),
        .mem_data_o       (mem_data),
        .mem_strb_o       (mem_strb),
        .mem_resp_valid_i (mem_resp_valid),
        .mem_resp_err_i   (mem_resp_err),
        .busy_o           (busy),
        .err_o            (err),
        .store_cnt_o      (store_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic sb_entry_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        sb_entry_t e;
        e.addr = a;
        e.data = d;
        e.strb = s;
        return e;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        sb_if.valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_err = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;
        exp_err = 1'b0;
    endtask

    // One full store: offer, stall rdly cycles, accept, respond after wdly idle WAIT cycles.
    task automatic drain_one(input sb_entry_t e, input int rdly, input int wdly,
                             input bit rsp_err, input bit stray);
        logic [31:0] ea;
        ea = {e.addr[31:2], 2'b00};
        sb_if.valid = 1'b1;
        sb_if.data  = e;
        mem_req_ready = $urandom_range(0, 1);
        @(negedge clk);
        check("accept_ready", sb_if.ready, 1'b1);
        tick();
        sb_if.valid = 1'b0;
        sb_if.data  = mk(e.addr ^ 32'h100, $urandom, 4'hF);
        for (int i = 0; i <= rdly; i++) begin
            mem_req_ready  = (i == rdly);
            mem_resp_valid = stray && (i < rdly);
            mem_resp_err   = stray && (i < rdly);
            @(negedge clk);
            check("req_valid", mem_req_valid, 1'b1);
            check("req_addr", mem_addr, ea);
            check("req_data", mem_data, e.data);
            check("req_strb", mem_strb, e.strb);
            check("req_busy", busy, 1'b1);
            check("req_rdy_low", sb_if.ready, 1'b0);
            tick();
        end
        mem_req_ready = 1'b0;
        for (int j = 0; j <= wdly; j++) begin
            mem_resp_valid = (j == wdly);
            mem_resp_err   = (j == wdly) ? rsp_err : 1'($urandom_range(0, 1));
            @(negedge clk);
            check("wait_req_low", mem_req_valid, 1'b0);
            check("wait_rdy_low", sb_if.ready, 1'b0);
            check("wait_cnt", store_cnt, exp_cnt);
            check("wait_err", err, exp_err);
            tick();
        end
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;
        exp_cnt++;
        exp_err = exp_err | rsp_err;
        @(negedge clk);
        check("done_cnt", store_cnt, exp_cnt);
        check("done_err", err, exp_err);
        check("done_busy", busy, 1'b0);
        check("done_rdy", sb_if.ready, 1'b1);
        tick();
    endtask

    initial begin
        sb_if.valid = 1'b0;
        sb_if.data  = '0;
        do_reset();
        @(negedge clk);
        check("rst_rdy", sb_if.ready, 1'b1);
        check("rst_req", mem_req_valid, 1'b0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_data", mem_data, 32'h0);
        check("rst_strb", mem_strb, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_cnt", store_cnt, 32'h0);
        tick();

        // Single store, zero-wait accept, response in the second WAIT cycle.
        drain_one(mk(32'h1000_0006, 32'hAABB_CCDD, 4'b1100), 0, 1, 1'b0, 1'b0);
        // Backpressure for 5 cycles, with stray responses that must be ignored.
        drain_one(mk(32'h0000_1233, 32'h1234_5678, 4'b0011), 5, 0, 1'b0, 1'b1);
        // Zero strobe is still a write.
        drain_one(mk(32'h0000_0040, 32'hDEAD_BEEF, 4'b0000), 1, 2, 1'b0, 1'b0);

        // Error then three clean writes from a fresh reset.
        do_reset();
        drain_one(mk(32'h0000_3000, 32'h0000_0001, 4'hF), 0, 0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++)
            drain_one(mk(32'h0000_3004 + 4 * k, $urandom, 4'hF), k, 0, 1'b0, 1'b0);
        check("err_sticky", err, 1'b1);
        check("err_cnt4", store_cnt, 32'd4);

        // Reset while in WAIT, then a late response.
        sb_if.valid = 1'b1;
        sb_if.data  = mk(32'h0000_5000, 32'h5555_AAAA, 4'hF);
        mem_req_ready = 1'b1;
        tick();
        sb_if.valid = 1'b0;
        tick();
        mem_req_ready = 1'b0;
        @(negedge clk);
        check("wait_before_rst", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;
        exp_err = 1'b0;
        @(negedge clk);
        check("rstw_busy", busy, 1'b0);
        check("rstw_req", mem_req_valid, 1'b0);
        check("rstw_cnt", store_cnt, 32'h0);
        check("rstw_err", err, 1'b0);
        check("rstw_rdy", sb_if.ready, 1'b1);
        mem_resp_valid = 1'b1;
        mem_resp_err   = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;
        @(negedge clk);
        check("late_rsp_cnt", store_cnt, 32'h0);
        check("late_rsp_err", err, 1'b0);
        tick();

`ifdef SB_DRAIN_MERGE_EN
        // Same-word entry merges into the stalled request.
        sb_if.valid = 1'b1;
        sb_if.data  = mk(32'h0000_2000, 32'h0000_00FF, 4'b0001);
        tick();
        sb_if.data  = mk(32'h0000_2002, 32'h00EE_0000, 4'b0100);
        @(negedge clk);
        check("merge_rdy", sb_if.ready, 1'b1);
        tick();
        sb_if.valid = 1'b0;
        sb_if.data  = mk(32'h0000_3000, 32'h0, 4'h0);
        @(negedge clk);
        check("merge_addr", mem_addr, 32'h0000_2000);
        check("merge_data", mem_data, 32'h00EE_00FF);
        check("merge_strb", mem_strb, 4'b0101);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        exp_cnt++;
        @(negedge clk);
        check("merge_cnt", store_cnt, exp_cnt);
        tick();
`else
        // Same-word entry must not be taken while a request is stalled.
        sb_if.valid = 1'b1;
        sb_if.data  = mk(32'h0000_2000, 32'h0000_00FF, 4'b0001);
        tick();
        sb_if.data  = mk(32'h0000_2002, 32'h00EE_0000, 4'b0100);
        @(negedge clk);
        check("nomerge_rdy", sb_if.ready, 1'b0);
        tick();
        @(negedge clk);
        check("nomerge_data", mem_data, 32'h0000_00FF);
        check("nomerge_strb", mem_strb, 4'b0001);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        exp_cnt++;
        drain_one(mk(32'h0000_2002, 32'h00EE_0000, 4'b0100), 0, 0, 1'b0, 1'b0);
`endif

        // Different-word entry waits for the first write to finish; order preserved.
        sb_if.valid = 1'b1;
        sb_if.data  = mk(32'h0000_2000, 32'h1111_1111, 4'hF);
        tick();
        sb_if.data  = mk(32'h0000_2004, 32'h2222_2222, 4'hF);
        @(negedge clk);
        check("miss_rdy0", sb_if.ready, 1'b0);
        check("miss_addr0", mem_addr, 32'h0000_2000);
        tick();
        @(negedge clk);
        check("miss_rdy1", sb_if.ready, 1'b0);
        check("miss_data0", mem_data, 32'h1111_1111);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        @(negedge clk);
        check("miss_rdy_wait", sb_if.ready, 1'b0);
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        exp_cnt++;
        drain_one(mk(32'h0000_2004, 32'h2222_2222, 4'hF), 0, 0, 1'b0, 1'b0);

        // Randomized drain traffic.
        for (int n = 0; n < 40; n++) begin
            drain_one(mk($urandom, $urandom, 4'($urandom_range(0, 15))),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_err   = 1'b1;
                tick();
                mem_resp_valid = 1'b0;
                mem_resp_err   = 1'b0;
                @(negedge clk);
                check("idle_stray_cnt", store_cnt, exp_cnt);
                check("idle_stray_err", err, exp_err);
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
